// File: rtl/msx_wait_gen_pkg.sv
// Shared types and default wait counts for the MSX wait-state generator.
package msx_wait_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    EXT   = 2'd2,
    HOLD  = 2'd3
  } wait_state_t;

  localparam int DEF_M1_WAITS  = 1;
  localparam int DEF_MEM_WAITS = 0;
  localparam int DEF_IO_WAITS  = 0;
  localparam int DEF_CNT_W     = 4;
  localparam int DEF_TIMEOUT   = 255;

  // Interrupt acknowledge gets one extra wait, clamped to what the counter can hold.
  function automatic int sat_inc(input int value, input int max_value);
    return (value >= max_value) ? max_value : value + 1;
  endfunction

endpackage

// File: rtl/msx_wait_gen_if.sv
// CPU bus strobes, external wait request and wait-generator status outputs.
interface msx_wait_gen_if;
  import msx_wait_gen_pkg::*;

  logic m1;
  logic mreq;
  logic iorq;
  logic rd;
  logic wr;
  logic ext_wait_n;
  logic wait_n;
  logic busy;
  logic timeout_flag;

  modport master (
    output m1, mreq, iorq, rd, wr, ext_wait_n,
    input  wait_n, busy, timeout_flag
  );

  modport slave (
    input  m1, mreq, iorq, rd, wr, ext_wait_n,
    output wait_n, busy, timeout_flag
  );

endinterface

// File: rtl/msx_wait_gen.sv
// Z80 wait-state generator for MSX: per-cycle-type wait counts plus external wait.
// Optional macro WAIT_TIMEOUT_EN adds a TIMEOUT-tick limit on external wait.
module msx_wait_gen
  import msx_wait_gen_pkg::*;
#(
  parameter int M1_WAITS  = DEF_M1_WAITS,
  parameter int MEM_WAITS = DEF_MEM_WAITS,
  parameter int IO_WAITS  = DEF_IO_WAITS,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce_3m58_p,
  msx_wait_gen_if.slave  bus
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] M1_LOAD   = CNT_W'(M1_WAITS);
  localparam logic [CNT_W-1:0] MEM_LOAD  = CNT_W'(MEM_WAITS);
  localparam logic [CNT_W-1:0] IO_LOAD   = CNT_W'(IO_WAITS);
  localparam logic [CNT_W-1:0] INTA_LOAD = CNT_W'(sat_inc(M1_WAITS, CNT_MAX));

  wait_state_t      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] load_val;
  logic             strobe, strobe_prev, cycle_start;
  logic             wait_n_r;

  assign strobe      = bus.mreq | bus.iorq;
  assign cycle_start = strobe & ~strobe_prev;

  always_comb begin
    load_val = MEM_LOAD;
    if (bus.m1 && bus.iorq) load_val = INTA_LOAD;
    else if (bus.m1)        load_val = M1_LOAD;
    else if (bus.iorq)      load_val = IO_LOAD;
  end

`ifdef WAIT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_reach, to_set, to_flag;

  assign to_reach = (to_cnt == TO_W'(TIMEOUT - 1));
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
`ifdef WAIT_TIMEOUT_EN
    to_set   = 1'b0;
`endif
    if (ce_3m58_p) begin
      case (state)
        IDLE: begin
          if (cycle_start) begin
            cnt_nx = load_val;
            if (load_val != '0)       state_nx = COUNT;
            else if (!bus.ext_wait_n) state_nx = EXT;
            else                      state_nx = HOLD;
          end
        end
        COUNT: begin
          // A strobe that drops mid-wait means the CPU aborted the cycle.
          if (!strobe) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt - CNT_W'(1);
            if (cnt <= CNT_W'(1)) state_nx = bus.ext_wait_n ? HOLD : EXT;
          end
        end
        EXT: begin
          if (!strobe) begin
            state_nx = IDLE;
          end
`ifdef WAIT_TIMEOUT_EN
          else if (to_reach) begin
            state_nx = HOLD;
            to_set   = 1'b1;
          end
`endif
          else if (bus.ext_wait_n) begin
            state_nx = HOLD;
          end
        end
        HOLD: begin
          if (!strobe) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // wait_n is decoded from the next state so it changes on the same tick as the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      strobe_prev <= 1'b0;
      wait_n_r    <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (ce_3m58_p) begin
        strobe_prev <= strobe;
        wait_n_r    <= !((state_nx == COUNT) || (state_nx == EXT));
      end
    end
  end

`ifdef WAIT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (ce_3m58_p) begin
        to_cnt <= ((state == EXT) && (state_nx == EXT)) ? to_cnt + TO_W'(1) : '0;
      end
      if (to_set) to_flag <= 1'b1;
    end
  end

  assign bus.timeout_flag = to_flag;
`else
  assign bus.timeout_flag = 1'b0;
`endif

  assign bus.wait_n = wait_n_r;
  assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_msx_wait_gen.sv
// Scoreboard bench for msx_wait_gen: expected wait lengths are queued per cycle.
// Build with WAIT_TIMEOUT_EN defined to exercise the external-wait timeout.
module tb_msx_wait_gen;
  import msx_wait_gen_pkg::*;

  logic clk;
  logic reset;
  logic ce_3m58_p;

  int tests_run;
  int tests_failed;
  int exp_q_a[$];
  int exp_q_b[$];

  msx_wait_gen_if bus_a ();
  msx_wait_gen_if bus_b ();

  assign bus_b.m1         = bus_a.m1;
  assign bus_b.mreq       = bus_a.mreq;
  assign bus_b.iorq       = bus_a.iorq;
  assign bus_b.rd         = bus_a.rd;
  assign bus_b.wr         = bus_a.wr;
  assign bus_b.ext_wait_n = bus_a.ext_wait_n;

  msx_wait_gen #(
    .M1_WAITS(1), .MEM_WAITS(3), .IO_WAITS(0), .CNT_W(4), .TIMEOUT(8)
  ) dut_a (
    .clk(clk), .reset(reset), .ce_3m58_p(ce_3m58_p), .bus(bus_a.slave)
  );

  // Second instance only exists to show interrupt-acknowledge saturation.
  msx_wait_gen #(
    .M1_WAITS(15), .MEM_WAITS(0), .IO_WAITS(0), .CNT_W(4), .TIMEOUT(8)
  ) dut_b (
    .clk(clk), .reset(reset), .ce_3m58_p(ce_3m58_p), .bus(bus_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    ce_3m58_p = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 ce_3m58_p = 1'b1;
      @(posedge clk);
      #1 ce_3m58_p = 1'b0;
    end
  end

  task automatic next_tick();
    do @(posedge clk); while (ce_3m58_p !== 1'b1);
    #2;
  endtask

  task automatic set_bus(input logic m1, input logic mreq, input logic iorq,
                         input logic rd, input logic wr);
    bus_a.m1   = m1;
    bus_a.mreq = mreq;
    bus_a.iorq = iorq;
    bus_a.rd   = rd;
    bus_a.wr   = wr;
  endtask

  // Starts a cycle and counts consecutive low wait_n ticks on both instances.
  task automatic run_cycle(input logic m1, input logic mreq, input logic iorq,
                           input logic rd, input logic wr, input int ext_low,
                           output int len_a, output int len_b);
    bit done_a;
    bit done_b;
    len_a  = 0;
    len_b  = 0;
    done_a = 1'b0;
    done_b = 1'b0;
    bus_a.ext_wait_n = (ext_low > 0) ? 1'b0 : 1'b1;
    set_bus(m1, mreq, iorq, rd, wr);
    for (int k = 0; k < 64 && !(done_a && done_b); k++) begin
      next_tick();
      if (!done_a) begin
        if (bus_a.wait_n === 1'b0) len_a++;
        else done_a = 1'b1;
      end
      if (!done_b) begin
        if (bus_b.wait_n === 1'b0) len_b++;
        else done_b = 1'b1;
      end
      bus_a.ext_wait_n = (k + 1 < ext_low) ? 1'b0 : 1'b1;
    end
    if (!done_a) len_a = 999;
    if (!done_b) len_b = 999;
  endtask

  task automatic end_cycle();
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_a.ext_wait_n = 1'b1;
    next_tick();
    next_tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_a.ext_wait_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    tests_run++;
    if (bus_a.wait_n !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_wait_n: got %b expected 1", bus_a.wait_n);
    end
    tests_run++;
    if (bus_a.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_busy: got %b expected 0", bus_a.busy);
    end
    tests_run++;
    if (bus_a.timeout_flag !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_timeout_flag: got %b expected 0", bus_a.timeout_flag);
    end
    reset = 1'b0;
    next_tick();
    next_tick();
  endtask

  task automatic test_m1_fetch();
    int len_a, len_b, exp;
    exp_q_a.push_back(1);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, len_a, len_b);
    exp = exp_q_a.pop_front();
    tests_run++;
    if (len_a !== exp) begin
      tests_failed++;
      $display("[TB] FAIL m1_fetch_len: got %0d expected %0d", len_a, exp);
    end
    next_tick();
    tests_run++;
    if (bus_a.wait_n !== 1'b1 || bus_a.busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL m1_hold: got wait_n=%b busy=%b expected wait_n=1 busy=1",
               bus_a.wait_n, bus_a.busy);
    end
    end_cycle();
    tests_run++;
    if (bus_a.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL m1_release_busy: got %b expected 0", bus_a.busy);
    end
  endtask

  task automatic test_mem_rw();
    int len_a, len_b, exp;
    exp_q_a.push_back(3);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, len_a, len_b);
    exp = exp_q_a.pop_front();
    tests_run++;
    if (len_a !== exp) begin
      tests_failed++;
      $display("[TB] FAIL mem_read_len: got %0d expected %0d", len_a, exp);
    end
    end_cycle();
    exp_q_a.push_back(3);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, len_a, len_b);
    exp = exp_q_a.pop_front();
    tests_run++;
    if (len_a !== exp) begin
      tests_failed++;
      $display("[TB] FAIL mem_write_len: got %0d expected %0d", len_a, exp);
    end
    end_cycle();
  endtask

  task automatic test_ext_wait();
    int len_a, len_b, exp;
    exp_q_a.push_back(5);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5, len_a, len_b);
    exp = exp_q_a.pop_front();
    tests_run++;
    if (len_a !== exp) begin
      tests_failed++;
      $display("[TB] FAIL io_ext_len: got %0d expected %0d", len_a, exp);
    end
    end_cycle();
  endtask

  task automatic test_inta();
    int len_a, len_b, exp;
    exp_q_a.push_back(2);
    exp_q_b.push_back(15);
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, len_a, len_b);
    exp = exp_q_a.pop_front();
    tests_run++;
    if (len_a !== exp) begin
      tests_failed++;
      $display("[TB] FAIL inta_len: got %0d expected %0d", len_a, exp);
    end
    exp = exp_q_b.pop_front();
    tests_run++;
    if (len_b !== exp) begin
      tests_failed++;
      $display("[TB] FAIL inta_saturate_len: got %0d expected %0d", len_b, exp);
    end
    end_cycle();
  endtask

  task automatic test_abort();
    bus_a.ext_wait_n = 1'b1;
    set_bus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    next_tick();
    tests_run++;
    if (bus_a.wait_n !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_start_wait_n: got %b expected 0", bus_a.wait_n);
    end
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_tick();
    tests_run++;
    if (bus_a.wait_n !== 1'b1 || bus_a.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_release: got wait_n=%b busy=%b expected wait_n=1 busy=0",
               bus_a.wait_n, bus_a.busy);
    end
    next_tick();
  endtask

  task automatic test_reset_mid_wait();
    bus_a.ext_wait_n = 1'b1;
    set_bus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    next_tick();
    next_tick();
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus_a.wait_n !== 1'b1 || bus_a.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_wait: got wait_n=%b busy=%b expected wait_n=1 busy=0",
               bus_a.wait_n, bus_a.busy);
    end
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    next_tick();
    next_tick();
  endtask

  task automatic test_back_to_back();
    int len_a, len_b, exp;
    exp_q_a.push_back(1);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, len_a, len_b);
    exp = exp_q_a.pop_front();
    tests_run++;
    if (len_a !== exp) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first_len: got %0d expected %0d", len_a, exp);
    end
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_tick();
    exp_q_a.push_back(1);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, len_a, len_b);
    exp = exp_q_a.pop_front();
    tests_run++;
    if (len_a !== exp) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second_len: got %0d expected %0d", len_a, exp);
    end
    end_cycle();
  endtask

  task automatic test_timeout();
    int len_a, len_b, exp;
    logic exp_flag;
`ifdef WAIT_TIMEOUT_EN
    exp_q_a.push_back(8);
    exp_flag = 1'b1;
`else
    exp_q_a.push_back(20);
    exp_flag = 1'b0;
`endif
    run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 20, len_a, len_b);
    exp = exp_q_a.pop_front();
    tests_run++;
    if (len_a !== exp) begin
      tests_failed++;
      $display("[TB] FAIL ext_timeout_len: got %0d expected %0d", len_a, exp);
    end
    end_cycle();
    tests_run++;
    if (bus_a.timeout_flag !== exp_flag) begin
      tests_failed++;
      $display("[TB] FAIL timeout_flag_sticky: got %b expected %b", bus_a.timeout_flag, exp_flag);
    end
    reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    tests_run++;
    if (bus_a.timeout_flag !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_flag_clear: got %b expected 0", bus_a.timeout_flag);
    end
    next_tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_a.ext_wait_n = 1'b1;
    test_reset();
    test_m1_fetch();
    test_mem_rw();
    test_ext_wait();
    test_inta();
    test_abort();
    test_reset_mid_wait();
    test_back_to_back();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
